// File: rtl/multdiv_unit_if.sv
// Operand/start and result/handshake bundle between the execute stage and multdiv_unit.
interface multdiv_unit_if;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/multdiv_unit.sv
// Sequential signed 32-bit multiply (radix-4 Booth, 16 steps) / divide (restoring, 32 steps).
// Latency 17 (MULT) / 33 (DIV) cycles from the start edge; a new start aborts any operation in flight.
module multdiv_unit (
    input  logic          clock,
    input  logic          reset_n,
    multdiv_unit_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_MULT, ST_DIV, ST_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_cnt;
    logic        r_load;
    logic [31:0] r_a, r_b;
    logic [64:0] r_prod;
    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_result;
    logic        r_exc;

    logic        w_start_mult, w_start_div, w_start;
    logic        w_mult_last, w_div_last;

    assign w_start_mult = bus.ctrl_MULT & ~bus.ctrl_DIV;
    assign w_start_div  = bus.ctrl_DIV & ~bus.ctrl_MULT;
    assign w_start      = w_start_mult | w_start_div;

    // The first cycle in MULT/DIV loads the working registers; the steps follow.
    assign w_mult_last = (r_state == ST_MULT) && !r_load && (r_cnt == 5'd15);
    assign w_div_last  = (r_state == ST_DIV)  && !r_load && (r_cnt == 5'd31);

    // Booth step: window {b[2i+1], b[2i], b[2i-1]} sits in the low three bits.
    logic [33:0] w_a_ext, w_pp, w_psum;
    logic [64:0] w_prod_nxt;
    logic        w_mult_ovf;

    assign w_a_ext = {{2{r_a[31]}}, r_a};

    always_comb begin
        w_pp = 34'd0;
        case (r_prod[2:0])
            3'b001, 3'b010: w_pp = w_a_ext;
            3'b011:         w_pp = w_a_ext << 1;
            3'b100:         w_pp = -(w_a_ext << 1);
            3'b101, 3'b110: w_pp = -w_a_ext;
            default:        w_pp = 34'd0;
        endcase
    end

    assign w_psum     = {{2{r_prod[64]}}, r_prod[64:33]} + w_pp;
    assign w_prod_nxt = {w_psum, r_prod[32:2]};
    assign w_mult_ovf = ~((&w_prod_nxt[64:32]) | ~(|w_prod_nxt[64:32]));

    // Restoring divide step on magnitudes.
    logic [31:0] w_abs_a, w_abs_b;
    logic [33:0] w_rem_sh, w_rem_diff;
    logic        w_fits;
    logic [32:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;

    assign w_abs_a    = r_a[31] ? -r_a : r_a;
    assign w_abs_b    = r_b[31] ? -r_b : r_b;
    assign w_rem_sh   = {r_rem, r_quo[31]};
    assign w_rem_diff = w_rem_sh - {2'b00, w_abs_b};
    assign w_fits     = ~w_rem_diff[33];
    assign w_rem_nxt  = w_fits ? w_rem_diff[32:0] : w_rem_sh[32:0];
    assign w_quo_nxt  = {r_quo[30:0], w_fits};

    logic [31:0] w_div_res;
    logic        w_div_exc;

    always_comb begin
        w_div_res = (r_a[31] ^ r_b[31]) ? -w_quo_nxt : w_quo_nxt;
        w_div_exc = 1'b0;
        if (r_b == 32'd0) begin
            w_div_res = 32'd0;
            w_div_exc = 1'b1;
        end else if (r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF) begin
            w_div_res = 32'h8000_0000;
            w_div_exc = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_MULT: if (w_mult_last) w_state_nxt = ST_DONE;
            ST_DIV:  if (w_div_last)  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = r_state;
        endcase
        if (w_start_mult)
            w_state_nxt = ST_MULT;
        else if (w_start_div)
            w_state_nxt = ST_DIV;
    end

    always_ff @(posedge clock) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt    <= 5'd0;
            r_load   <= 1'b0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_prod   <= 65'd0;
            r_rem    <= 33'd0;
            r_quo    <= 32'd0;
            r_result <= 32'd0;
            r_exc    <= 1'b0;
        end else if (w_start) begin
            r_a    <= bus.data_operandA;
            r_b    <= bus.data_operandB;
            r_cnt  <= 5'd0;
            r_load <= 1'b1;
        end else begin
            if (r_state == ST_MULT) begin
                if (r_load) begin
                    r_prod <= {32'd0, r_b, 1'b0};
                    r_load <= 1'b0;
                end else begin
                    r_prod <= w_prod_nxt;
                    r_cnt  <= r_cnt + 5'd1;
                end
            end else if (r_state == ST_DIV) begin
                if (r_load) begin
                    r_rem  <= 33'd0;
                    r_quo  <= w_abs_a;
                    r_load <= 1'b0;
                end else begin
                    r_rem  <= w_rem_nxt;
                    r_quo  <= w_quo_nxt;
                    r_cnt  <= r_cnt + 5'd1;
                end
            end
            if (w_mult_last) begin
                r_result <= w_mult_ovf ? 32'd0 : w_prod_nxt[32:1];
                r_exc    <= w_mult_ovf;
            end else if (w_div_last) begin
                r_result <= w_div_res;
                r_exc    <= w_div_exc;
            end
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = (r_state == ST_DONE);
endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: driver pushes expected completions, monitor checks each ready pulse.
module tb_multdiv_unit;
    logic clock;
    logic reset_n;
    multdiv_unit_if bus();

    multdiv_unit dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) edge_cnt++;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", nm, act, exp_v, edge_cnt);
        end
    endtask

    function automatic exp_t model(bit is_div, logic [31:0] a, logic [31:0] b, int due);
        exp_t   e;
        longint p;
        int     ia, ib;
        e.due = due;
        if (!is_div) begin
            p = longint'(signed'(a)) * longint'(signed'(b));
            e.exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
            e.res = e.exc ? 32'd0 : p[31:0];
        end else if (b == 32'd0) begin
            e.exc = 1'b1;
            e.res = 32'd0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.exc = 1'b1;
            e.res = 32'h8000_0000;
        end else begin
            ia = signed'(a);
            ib = signed'(b);
            e.exc = 1'b0;
            e.res = 32'(ia / ib);
        end
        return e;
    endfunction

    // Called at a falling edge; the start is sampled at the next rising edge.
    task automatic start_op(bit is_div, logic [31:0] a, logic [31:0] b);
        int se;
        se = edge_cnt + 1;
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].due >= se) sb.delete(i);
        sb.push_back(model(is_div, a, b, se + (is_div ? 33 : 17)));
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = !is_div;
        bus.ctrl_DIV      = is_div;
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    task automatic wait_rdy(int budget);
        int n;
        n = 0;
        while (bus.data_resultRDY !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (n >= budget) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_rdy: got no ready within %0d cycles required one", budget);
        end
    endtask

    task automatic drain(int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending results required 0", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [31:0] rnd_opnd();
        logic [31:0] v;
        logic [31:0] sp [5];
        sp[0] = 32'd0; sp[1] = 32'd1; sp[2] = 32'hFFFF_FFFF;
        sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF;
        case ($urandom_range(0, 3))
            0:       v = $urandom;
            1:       v = 32'($urandom_range(0, 200)) - 32'd100;
            2:       v = sp[$urandom_range(0, 4)];
            default: v = $urandom >> $urandom_range(0, 31);
        endcase
        return v;
    endfunction

    // Monitor: every ready pulse must match the oldest expected completion, on its cycle.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n === 1'b1) begin
            if (bus.data_resultRDY === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_rdy: got ready at edge %0d required none", edge_cnt);
                end else begin
                    e = sb.pop_front();
                    check("rdy_edge", 32'(edge_cnt), 32'(e.due));
                    check("result", bus.data_result, e.res);
                    check("exception", {31'd0, bus.data_exception}, {31'd0, e.exc});
                end
            end else if (sb.size() != 0 && sb[0].due < edge_cnt) begin
                n_cmp++;
                n_err++;
                $display("FAIL missing_rdy: got no ready at edge %0d required one", sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    bit          d_div [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    logic [31:0] d_a   [8] = '{32'd7, 32'h8000_0000, 32'h0001_0000, 32'hFFFF_FFFF,
                               32'hFFFF_FFF9, 32'd5, 32'h8000_0000, 32'd100};
    logic [31:0] d_b   [8] = '{32'hFFFF_FFFD, 32'd1, 32'h0001_0000, 32'hFFFF_FFFF,
                               32'd2, 32'd0, 32'hFFFF_FFFF, 32'd7};

    initial begin
        reset_n           = 1'b0;
        bus.data_operandA = 32'd0;
        bus.data_operandB = 32'd0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge clock);
            check("idle_result", bus.data_result, 32'd0);
            check("idle_exception", {31'd0, bus.data_exception}, 32'd0);
            check("idle_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            start_op(d_div[i], d_a[i], d_b[i]);
            wait_rdy(40);
            @(negedge clock);
        end
        check("result_held", bus.data_result, 32'd14);

        // DIV aborted by a MULT started ten cycles later.
        start_op(1'b1, 32'd100, 32'd7);
        repeat (9) @(negedge clock);
        start_op(1'b0, 32'd6, 32'd7);
        drain(40);
        repeat (30) @(negedge clock);
        check("abort_result", bus.data_result, 32'd42);

        // Reset in the middle of a MULT.
        start_op(1'b0, 32'd123, 32'd456);
        repeat (4) @(negedge clock);
        reset_n = 1'b0;
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1;
        check("rst_result", bus.data_result, 32'd0);
        check("rst_exception", {31'd0, bus.data_exception}, 32'd0);
        repeat (40) @(negedge clock);

        // Both start pulses together are ignored.
        bus.data_operandA = 32'd9;
        bus.data_operandB = 32'd9;
        bus.ctrl_MULT     = 1'b1;
        bus.ctrl_DIV      = 1'b1;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        repeat (40) @(negedge clock);
        check("both_result", bus.data_result, 32'd0);

        for (int i = 0; i < 60; i++) begin
            start_op(1'($urandom_range(0, 1)), rnd_opnd(), rnd_opnd());
            case ($urandom_range(0, 2))
                0:       wait_rdy(40);
                1:       repeat ($urandom_range(0, 20)) @(negedge clock);
                default: begin drain(40); repeat (2) @(negedge clock); end
            endcase
        end
        drain(100);
        repeat (3) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
